// File: rtl/elc3_datapath_hs.sv
// elc3_datapath_hs: eLC-3 datapath with gated bus, register file, ALU, address adder and req/ack memory sequencer
//
// Ports:
//   Clk, Reset            clock and synchronous active-low reset
//   LD_*                  register load strobes (MAR, MDR, IR, BEN, REG, CC, PC)
//   Gate*                 bus driver enables (PC, MDR, ALU, MARMUX)
//   *MUX, ALUK            datapath steering from the control FSM
//   MIO_EN, R_W           memory operation request and direction
//   Mem_Req/WE/Addr/WData memory request side, Mem_RData/Mem_Ack memory response side
//   R                     memory operation complete
//   BEN, IR               branch enable and instruction register to control
//   Bus_Err               sticky flag set when more than one bus driver is enabled
module elc3_datapath_hs #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              LD_BEN,
    input  logic              LD_REG,
    input  logic              LD_CC,
    input  logic              LD_PC,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic              ADDR1MUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [1:0]        PCMUX,
    input  logic [1:0]        DRMUX,
    input  logic [1:0]        SR1MUX,
    input  logic              SR2MUX,
    input  logic              MARMUX,
    input  logic [1:0]        ALUK,
    input  logic              MIO_EN,
    input  logic              R_W,
    output logic              Mem_Req,
    output logic              Mem_WE,
    output logic [DATA_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    input  logic              Mem_Ack,
    output logic              R,
    output logic              BEN,
    output logic [15:0]       IR,
    output logic              Bus_Err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} seq_t;

    seq_t              state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic              ben_q, ben_d;
    logic              n_q, n_d;
    logic              z_q, z_d;
    logic              p_q, p_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] sext5, sext6, sext9, sext11, zext8;
    logic [DATA_W-1:0] addr1, addr2, addr;
    logic [DATA_W-1:0] sr1, sr2, alu_b, alu;
    logic [DATA_W-1:0] marmux, pcmux, bus;
    logic [2:0]        sr1_sel, dr_sel;
    logic [2:0]        gate_cnt;

    // Offset and immediate extension; instruction fields always come from IR[15:0]
    always_comb begin
        sext5  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
        sext6  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
        sext9  = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
        sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};
        zext8  = {{(DATA_W-8){1'b0}}, ir_q[7:0]};
    end

    // Register selection, combinational register-file reads and ALU
    always_comb begin
        sr1_sel = (SR1MUX == 2'd0) ? ir_q[11:9] :
                  (SR1MUX == 2'd1) ? ir_q[8:6]  : 3'd6;
        dr_sel  = (DRMUX == 2'd0) ? ir_q[11:9] :
                  (DRMUX == 2'd2) ? 3'd6       : 3'd7;
        sr1     = regs_q[sr1_sel];
        sr2     = regs_q[ir_q[2:0]];
        alu_b   = SR2MUX ? sext5 : sr2;
        alu     = (ALUK == 2'd0) ? sr1 + alu_b :
                  (ALUK == 2'd1) ? sr1 & alu_b :
                  (ALUK == 2'd2) ? ~sr1        : sr1;
    end

    // Address adder, MARMUX and PC source selection; all sums wrap at DATA_W
    always_comb begin
        addr1  = ADDR1MUX ? sr1 : pc_q;
        addr2  = (ADDR2MUX == 2'd0) ? '0    :
                 (ADDR2MUX == 2'd1) ? sext6 :
                 (ADDR2MUX == 2'd2) ? sext9 : sext11;
        addr   = addr1 + addr2;
        marmux = MARMUX ? addr : zext8;
        pcmux  = (PCMUX == 2'd0) ? pc_q + DATA_W'(1) :
                 (PCMUX == 2'd1) ? bus               :
                 (PCMUX == 2'd2) ? addr              : pc_q;
    end

    // Gated bus: with several drivers enabled the sources are ORed, mimicking
    // a wired bus, and the contention is recorded in Bus_Err
    always_comb begin
        bus      = (GateMARMUX ? marmux : '0) |
                   (GateALU    ? alu    : '0) |
                   (GateMDR    ? mdr_q  : '0) |
                   (GatePC     ? pc_q   : '0);
        gate_cnt = {2'b0, GateMARMUX} + {2'b0, GateALU} + {2'b0, GateMDR} + {2'b0, GatePC};
    end

    // Architectural register next-state
    always_comb begin
        regs_d = regs_q;
        if (LD_REG)
            regs_d[dr_sel] = bus;
        pc_d  = LD_PC  ? pcmux     : pc_q;
        mar_d = LD_MAR ? bus       : mar_q;
        ir_d  = LD_IR  ? bus[15:0] : ir_q;
        // With MIO_EN high the MDR takes the word captured by the sequencer
        mdr_d = LD_MDR ? (MIO_EN ? rbuf_q : bus) : mdr_q;
        n_d   = LD_CC ? bus[DATA_W-1]                   : n_q;
        z_d   = LD_CC ? (bus == '0)                     : z_q;
        p_d   = LD_CC ? (~bus[DATA_W-1] & (bus != '0))  : p_q;
        // BEN uses the condition codes as they stand before this edge
        ben_d = LD_BEN ? ((ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q)) : ben_q;
        err_d = err_q | (gate_cnt > 3'd1);
    end

    // Sequencer next-state; an access is never aborted once started
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = MIO_EN ? ACCESS : IDLE;
            ACCESS:  state_d = Mem_Ack ? (MIO_EN ? DONE : IDLE) : ACCESS;
            DONE:    state_d = MIO_EN ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        we_d   = (state_q == IDLE && MIO_EN) ? R_W : we_q;
        rbuf_d = (state_q == ACCESS && Mem_Ack && !we_q) ? Mem_RData : rbuf_q;
    end

    // Sequencer outputs, all decoded from registered state
    always_comb begin
        Mem_Req = (state_q == ACCESS);
        R       = (state_q == DONE);
        Mem_WE  = we_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q   <= PC_RESET;
            mar_q  <= '0;
            mdr_q  <= '0;
            rbuf_q <= '0;
            ir_q   <= '0;
            for (int i = 0; i < 8; i++)
                regs_q[i] <= '0;
            ben_q  <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b1;
            p_q    <= 1'b0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
            rbuf_q <= rbuf_d;
            ir_q   <= ir_d;
            regs_q <= regs_d;
            ben_q  <= ben_d;
            n_q    <= n_d;
            z_q    <= z_d;
            p_q    <= p_d;
            we_q   <= we_d;
            err_q  <= err_d;
        end
    end

    assign Mem_Addr  = mar_q;
    assign Mem_WData = mdr_q;
    assign BEN       = ben_q;
    assign IR        = ir_q;
    assign Bus_Err   = err_q;

endmodule

// File: tb/tb_elc3_datapath_hs.sv
// tb_elc3_datapath_hs: directed self-checking bench for elc3_datapath_hs (16- and 32-bit instances)
module tb_elc3_datapath_hs;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic        ADDR1MUX, SR2MUX, MARMUX;
    logic [1:0]  ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
    logic        MIO_EN, R_W, Mem_Ack;
    logic [15:0] Mem_RData;

    logic        Mem_Req, Mem_WE, R, BEN, Bus_Err;
    logic [15:0] Mem_Addr, Mem_WData, IR;

    logic        Mem_Req32, Mem_WE32, R32, BEN32, Bus_Err32;
    logic [31:0] Mem_Addr32, Mem_WData32;
    logic [15:0] IR32;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    elc3_datapath_hs #(.DATA_W(16), .PC_RESET(16'h3000)) dut (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
        .MIO_EN(MIO_EN), .R_W(R_W),
        .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack),
        .R(R), .BEN(BEN), .IR(IR), .Bus_Err(Bus_Err)
    );

    elc3_datapath_hs #(.DATA_W(32), .PC_RESET(32'hFFFF_FFFF)) dut32 (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MARMUX(MARMUX), .ALUK(ALUK),
        .MIO_EN(MIO_EN), .R_W(R_W),
        .Mem_Req(Mem_Req32), .Mem_WE(Mem_WE32), .Mem_Addr(Mem_Addr32), .Mem_WData(Mem_WData32),
        .Mem_RData({16'h0, Mem_RData}), .Mem_Ack(Mem_Ack),
        .R(R32), .BEN(BEN32), .IR(IR32), .Bus_Err(Bus_Err32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
        {ADDR1MUX, SR2MUX, MARMUX} = '0;
        {ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK} = '0;
    endtask

    // Read with the memory acknowledging on the first Req cycle, then load MDR from the read buffer
    task automatic mem_read(input logic [15:0] d);
        MIO_EN = 1'b1;
        R_W = 1'b0;
        Mem_RData = d;
        for (int i = 0; i < 20 && !R; i++) begin
            tick();
            Mem_Ack = Mem_Req;
        end
        Mem_Ack = 1'b0;
        check("rd_done", R, 1);
        LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0;
        MIO_EN = 1'b0;
        tick();
    endtask

    task automatic load_ir(input logic [15:0] w);
        mem_read(w);
        GateMDR = 1'b1;
        LD_IR = 1'b1;
        tick();
        clear_ctl();
    endtask

    task automatic load_reg(input logic [2:0] dr, input logic [15:0] v);
        load_ir({4'h0, dr, 9'h0});
        mem_read(v);
        GateMDR = 1'b1;
        LD_REG = 1'b1;
        tick();
        clear_ctl();
    endtask

    initial begin
        int req_cycles;
        Reset = 1'b0;
        clear_ctl();
        MIO_EN = 1'b0;
        R_W = 1'b0;
        Mem_Ack = 1'b0;
        Mem_RData = '0;
        tick();
        tick();
        Reset = 1'b1;

        check("rst_pc", dut.pc_q, 16'h3000);
        check("rst_z", dut.z_q, 1);
        check("rst_n", dut.n_q, 0);
        check("rst_r", R, 0);
        check("rst_req", Mem_Req, 0);
        check("rst_err", Bus_Err, 0);
        check("rst_ir", IR, 0);
        check("rst_mar", Mem_Addr, 0);

        // Fetch-style step: MAR<-PC, IR<-PC, PC<-PC+1 in both widths
        GatePC = 1'b1; LD_MAR = 1'b1; LD_IR = 1'b1; LD_PC = 1'b1; PCMUX = 2'd0;
        tick();
        clear_ctl();
        check("fetch_mar", Mem_Addr, 16'h3000);
        check("fetch_ir", IR, 16'h3000);
        check("fetch_pc", dut.pc_q, 16'h3001);
        check("w32_mar", Mem_Addr32, 32'hFFFF_FFFF);
        check("w32_pc_wrap", dut32.pc_q, 32'h0);
        check("w32_ir", IR32, 16'hFFFF);

        GatePC = 1'b1; LD_MAR = 1'b1;
        tick();
        clear_ctl();
        check("pc_to_mar", Mem_Addr, 16'h3001);
        check("w32_pc_to_mar", Mem_Addr32, 32'h0);

        // PC + SEXT(IR[8:0]); IR[8:0]=1FF in the 32-bit instance, 000 in the 16-bit one
        GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR1MUX = 1'b0; ADDR2MUX = 2'd2; LD_MAR = 1'b1;
        tick();
        clear_ctl();
        check("w32_sext9", Mem_Addr32, 32'hFFFF_FFFF);
        check("addr_off0", Mem_Addr, 16'h3001);

        // Read with ack on the second Req cycle
        MIO_EN = 1'b1;
        R_W = 1'b0;
        Mem_RData = 16'h1234;
        req_cycles = 0;
        for (int i = 0; i < 20 && !R; i++) begin
            tick();
            Mem_Ack = 1'b0;
            if (Mem_Req) begin
                req_cycles++;
                if (req_cycles == 1) check("rd_addr", Mem_Addr, 16'h3001);
                if (req_cycles == 2) Mem_Ack = 1'b1;
            end
        end
        Mem_Ack = 1'b0;
        check("rd_req_cycles", req_cycles, 2);
        check("rd_r", R, 1);
        check("rd_req_low", Mem_Req, 0);
        check("rd_we", Mem_WE, 0);
        LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0;
        check("rd_mdr", Mem_WData, 16'h1234);
        check("rd_r_hold", R, 1);
        MIO_EN = 1'b0;
        tick();
        check("rd_r_drop", R, 0);

        // ALU and condition codes: R1=7FFF, R2=0001, ADD R3,R1,R2
        load_reg(3'd1, 16'h7FFF);
        load_reg(3'd2, 16'h0001);
        load_ir(16'h1642);
        GateALU = 1'b1; ALUK = 2'd0; SR1MUX = 2'd1; SR2MUX = 1'b0; DRMUX = 2'd0;
        LD_REG = 1'b1; LD_CC = 1'b1;
        tick();
        clear_ctl();
        check("add_n", dut.n_q, 1);
        check("add_z", dut.z_q, 0);
        check("add_p", dut.p_q, 0);
        GateALU = 1'b1; ALUK = 2'd3; SR1MUX = 2'd0; LD_MAR = 1'b1;
        tick();
        clear_ctl();
        check("add_r3", Mem_Addr, 16'h8000);

        // AND R4,R3,#0
        load_ir(16'h58E0);
        GateALU = 1'b1; ALUK = 2'd1; SR1MUX = 2'd1; SR2MUX = 1'b1; DRMUX = 2'd0;
        LD_REG = 1'b1; LD_CC = 1'b1;
        tick();
        clear_ctl();
        check("and_z", dut.z_q, 1);
        check("and_n", dut.n_q, 0);
        check("and_p", dut.p_q, 0);

        // NOT R3 (8000) onto the bus -> 7FFF
        GateALU = 1'b1; ALUK = 2'd2; SR1MUX = 2'd1; LD_MAR = 1'b1;
        tick();
        clear_ctl();
        check("not_r3", Mem_Addr, 16'h7FFF);

        load_ir(16'h0200);
        LD_BEN = 1'b1;
        tick();
        clear_ctl();
        check("ben_brp", BEN, 0);
        load_ir(16'h0400);
        LD_BEN = 1'b1;
        tick();
        clear_ctl();
        check("ben_brz", BEN, 1);

        // Write: MAR=4000, MDR=ABCD
        mem_read(16'h4000);
        GateMDR = 1'b1; LD_MAR = 1'b1;
        tick();
        clear_ctl();
        mem_read(16'hABCD);
        MIO_EN = 1'b1;
        R_W = 1'b1;
        Mem_RData = 16'h5555;
        for (int i = 0; i < 20 && !R; i++) begin
            tick();
            if (Mem_Req) begin
                check("wr_we", Mem_WE, 1);
                check("wr_addr", Mem_Addr, 16'h4000);
                check("wr_data", Mem_WData, 16'hABCD);
            end
            Mem_Ack = Mem_Req;
        end
        Mem_Ack = 1'b0;
        check("wr_done", R, 1);
        check("wr_rbuf", dut.rbuf_q, 16'hABCD);
        MIO_EN = 1'b0;
        R_W = 1'b0;
        tick();
        check("wr_r_drop", R, 0);

        // Reset in the middle of an access, then a late ack in IDLE
        MIO_EN = 1'b1;
        tick();
        check("mid_req", Mem_Req, 1);
        Reset = 1'b0;
        tick();
        check("mid_rst_req", Mem_Req, 0);
        Reset = 1'b1;
        MIO_EN = 1'b0;
        Mem_Ack = 1'b1;
        tick();
        Mem_Ack = 1'b0;
        check("late_ack_r", R, 0);
        check("late_ack_req", Mem_Req, 0);
        check("rst_pc2", dut.pc_q, 16'h3000);

        // Bus contention
        check("err_pre", Bus_Err, 0);
        GateALU = 1'b1; GatePC = 1'b1;
        tick();
        clear_ctl();
        check("err_set", Bus_Err, 1);
        for (int i = 0; i < 10; i++) tick();
        check("err_sticky", Bus_Err, 1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("err_clear", Bus_Err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
